// File: rtl/alu23_operand_skid.sv
// Two-entry operand skid buffer feeding the execute-stage address adder.
// Ports: clk, rst_n, in_* (valid/ready + op1/op2/tag), flush,
//   out_* (valid/ready + head op1/op2/tag), occupancy (0..2).
// Optional: define ALU23_SKID_STALL_CNT_EN to add stall_cnt[15:0],
//   a saturating count of cycles with out_valid=1 & out_ready=0.
module alu23_operand_skid #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
`ifdef ALU23_SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nxt;
  ent_t   r_h;
  ent_t   r_s;
  ent_t   w_in;
  logic   w_acc;
  logic   w_iss;
  logic   w_ld_h_in;
  logic   w_ld_h_s;
  logic   w_ld_s;

  assign w_in = {in_op1, in_op2, in_tag};

  // Handshake decoded from registered state only.
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_acc     = in_valid & in_ready;
  assign w_iss     = out_valid & out_ready;

  assign out_op1   = r_h.op1;
  assign out_op2   = r_h.op2;
  assign out_tag   = r_h.tag;
  assign occupancy = r_state;

  always_comb begin
    w_nxt     = r_state;
    w_ld_h_in = 1'b0;
    w_ld_h_s  = 1'b0;
    w_ld_s    = 1'b0;
    if (flush) begin
      w_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_acc) begin
            w_nxt     = ONE;
            w_ld_h_in = 1'b1;
          end
        end
        ONE: begin
          unique case (1'b1)
            (w_acc & w_iss): begin
              w_ld_h_in = 1'b1;
            end
            (w_acc & ~w_iss): begin
              w_nxt  = FULL;
              w_ld_s = 1'b1;
            end
            (~w_acc & w_iss): begin
              w_nxt = EMPTY;
            end
            default: begin
              w_nxt = ONE;
            end
          endcase
        end
        FULL: begin
          if (w_iss) begin
            w_nxt    = ONE;
            w_ld_h_s = 1'b1;
          end
        end
        default: begin
          w_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Data is not cleared by flush; only occupancy is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_s <= '0;
    end else begin
      if (w_ld_h_in) begin
        r_h <= w_in;
      end else if (w_ld_h_s) begin
        r_h <= r_s;
      end
      if (w_ld_s) begin
        r_s <= w_in;
      end
    end
  end

`ifdef ALU23_SKID_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready &&
                 (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_alu23_operand_skid.sv
// Scoreboard bench for alu23_operand_skid: directed cases then
// random traffic checked against a queue model of the buffer.
module tb_alu23_operand_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_op1 = '0;
  logic [15:0] in_op2 = '0;
  logic [2:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_op1;
  logic [15:0] out_op2;
  logic [2:0]  out_tag;
  logic [1:0]  occupancy;
`ifdef ALU23_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  alu23_operand_skid #(.DATA_W(16), .TAG_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op1   (out_op1),
    .out_op2   (out_op2),
    .out_tag   (out_tag),
    .occupancy (occupancy)
`ifdef ALU23_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  t;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   stall_exp = 0;
  bit   mon_en = 1'b0;
  bit   beef_seen = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  always @(negedge rst_n) begin
    q.delete();
    stall_exp = 0;
  end

  // Monitor: compare DUT against model, then advance model
  // by what the coming clock edge will do.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      bit acc;
      bit iss;
      chk("occupancy", 32'(occupancy), q.size());
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
      if (q.size() != 0) begin
        chk("out_op1", 32'(out_op1), 32'(q[0].a));
        chk("out_op2", 32'(out_op2), 32'(q[0].b));
        chk("out_tag", 32'(out_tag), 32'(q[0].t));
        if (out_op1 == 16'hBEEF) beef_seen = 1'b1;
      end
`ifdef ALU23_SKID_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), stall_exp);
`endif
      acc = in_valid && (q.size() < 2);
      iss = out_ready && (q.size() > 0);
      if (q.size() > 0 && !out_ready && stall_exp < 65535)
        stall_exp++;
      if (flush) begin
        q.delete();
      end else begin
        if (iss) void'(q.pop_front());
        if (acc) q.push_back({in_op1, in_op2, in_tag});
      end
    end
  end

  task automatic push(input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [2:0]  t);
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    in_tag   = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_op1", 32'(out_op1), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // single push
    out_ready = 1'b1;
    push(16'h1234, 16'h0010, 3'd3);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_op1", 32'(out_op1), 32'h1234);
    chk("single_op2", 32'(out_op2), 32'h0010);
    chk("single_tag", 32'(out_tag), 3);
    @(posedge clk); #1;
    chk("single_gone", 32'(out_valid), 0);

    // back-pressure
    out_ready = 1'b0;
    push(16'h0001, 16'h0, 3'd1);
    push(16'h0002, 16'h0, 3'd2);
    chk("bp_occ", 32'(occupancy), 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_headA", 32'(out_op1), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_headB", 32'(out_op1), 2);
    @(posedge clk); #1;
    chk("bp_drained", 32'(occupancy), 0);

    // streaming
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_op1   = 16'(i);
      in_op2   = 16'(i * 3);
      in_tag   = 3'(i);
      @(posedge clk); #1;
      chk("stream_occ_le1", 32'(occupancy <= 2'd1), 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_done", 32'(occupancy), 0);

    // flush while full with simultaneous input
    out_ready = 1'b0;
    push(16'hAAAA, 16'h1111, 3'd4);
    push(16'h5555, 16'h2222, 3'd5);
    in_valid = 1'b1;
    in_op1   = 16'hBEEF;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_beef", 32'(beef_seen), 0);

    // stall count + async reset with FULL buffer
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(16'h0A0A, 16'h0B0B, 3'd6);
    push(16'h0C0C, 16'h0D0D, 3'd7);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_occ", 32'(occupancy), 2);
`ifdef ALU23_SKID_STALL_CNT_EN
    chk("stall_5", 32'(stall_cnt), 5);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", 32'(occupancy), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_op1", 32'(out_op1), 0);
    chk("arst_op2", 32'(out_op2), 0);
    chk("arst_tag", 32'(out_tag), 0);
`ifdef ALU23_SKID_STALL_CNT_EN
    chk("arst_stall", 32'(stall_cnt), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // random traffic, holding data while stalled
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom % 4) != 0;
        in_op1   = 16'($urandom);
        in_op2   = 16'($urandom);
        in_tag   = 3'($urandom);
      end
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 32) == 0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("final_empty", 32'(occupancy), 0);
    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
